// File: rtl/ddp_scaler.sv
// Display data processor: integer-upscales a canvas from frame RAM onto the screen,
// issuing canvas read addresses and applying a per-frame colour mode to the returned pixels.
module ddp_scaler #(
   parameter int DW     = 15,
   parameter int H_LEN  = 200,
   parameter int V_LEN  = 150,
   parameter int SCALE  = 4,
   parameter int CW     = 4,
   parameter int RD_LAT = 1
) (
   input  logic            pclk,
   input  logic            rstn,
   input  logic            hen,
   input  logic            ven,
   input  logic [1:0]      mode,
   input  logic [3*CW-1:0] rdata,
   output logic [DW-1:0]   raddr,
   output logic [3*CW-1:0] rgb,
   output logic            de,
   output logic            frame_done
);
   localparam int SXW = $clog2(SCALE + 1);
   localparam int PXW = $clog2(H_LEN + 1);
   localparam int PYW = $clog2(V_LEN + 1);

   typedef enum logic [1:0] {M_PASS, M_BLEND, M_GRAY, M_DIM} mode_e;

   logic [SXW-1:0]    sx, sy;
   logic [PXW-1:0]    px;
   logic [PYW-1:0]    py;
   logic [DW-1:0]     line_base;
   logic              ovr, hen_d, ven_d;
   mode_e             mode_q;
   logic [RD_LAT-1:0] act_pipe, ovr_pipe;
   logic [3*CW-1:0]   prev, pix;

   logic act, py_end, st_act, st_ovr;
   assign act    = hen && ven;
   assign py_end = (py == PYW'(V_LEN));
   assign st_act = act_pipe[RD_LAT-1];
   assign st_ovr = ovr_pipe[RD_LAT-1];

   // Address generator: counters and raddr advance with the scaled raster.
   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge pclk) begin
      if (!rstn) begin
         sx <= '0; sy <= '0; px <= '0; py <= '0;
         line_base <= '0; raddr <= '0; ovr <= 1'b0;
         hen_d <= 1'b0; ven_d <= 1'b0; frame_done <= 1'b0;
         mode_q <= M_PASS;
      end else begin
         hen_d      <= hen;
         ven_d      <= ven;
         frame_done <= 1'b0;
         if (!ven) mode_q <= mode_e'(mode);
         if (ven_d && !ven) begin
            // Frame end wins over a coincident line end.
            sx <= '0; sy <= '0; px <= '0; py <= '0;
            line_base <= '0; raddr <= '0; ovr <= 1'b0;
            frame_done <= 1'b1;
         end else if (hen_d && !hen && ven) begin
            sx  <= '0;
            px  <= '0;
            ovr <= 1'b0;
            if (sy == SXW'(SCALE - 1)) begin
               sy <= '0;
               if (!py_end) begin
                  py        <= py + PYW'(1);
                  line_base <= line_base + DW'(H_LEN);
                  raddr     <= line_base + DW'(H_LEN);
               end else begin
                  raddr <= line_base;
               end
            end else begin
               sy    <= sy + SXW'(1);
               raddr <= line_base;
            end
         end else if (act) begin
            if (sx == SXW'(SCALE - 1)) begin
               sx <= '0;
               if (px == PXW'(H_LEN - 1)) begin
                  ovr <= 1'b1;
               end else if (!ovr && !py_end) begin
                  px    <= px + PXW'(1);
                  raddr <= raddr + DW'(1);
               end
            end else begin
               sx <= sx + SXW'(1);
            end
         end
      end
   end

   // Delay line aligning the active/overrun flags with rdata.
   always_ff @(posedge pclk) begin
      if (!rstn) begin
         act_pipe <= '0;
         ovr_pipe <= '0;
      end else begin
         act_pipe[0] <= act;
         ovr_pipe[0] <= ovr || py_end;
         for (int i = 1; i < RD_LAT; i++) begin
            act_pipe[i] <= act_pipe[i-1];
            ovr_pipe[i] <= ovr_pipe[i-1];
         end
      end
   end

   logic [CW+1:0] r, g, b, pr, pg, pb, y;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      r   = {2'b00, rdata[2*CW +: CW]};
      g   = {2'b00, rdata[CW +: CW]};
      b   = {2'b00, rdata[0 +: CW]};
      pr  = {2'b00, prev[2*CW +: CW]};
      pg  = {2'b00, prev[CW +: CW]};
      pb  = {2'b00, prev[0 +: CW]};
      y   = (r + (g << 1) + b) >> 2;
      pix = rdata;
      case (mode_q)
         M_PASS:  pix = rdata;
         // de still low means this is the first pixel of the screen line.
         M_BLEND: if (de) pix = {CW'((r + pr) >> 1), CW'((g + pg) >> 1), CW'((b + pb) >> 1)};
         M_GRAY:  pix = {CW'(y), CW'(y), CW'(y)};
         M_DIM:   pix = {CW'(r >> 1), CW'(g >> 1), CW'(b >> 1)};
         default: pix = rdata;
      endcase
      if (st_ovr) pix = '0;
   end

   // Output stage; prev tracks the last displayed pixel and drops to zero between lines.
   always_ff @(posedge pclk) begin
      if (!rstn) begin
         rgb  <= '0;
         de   <= 1'b0;
         prev <= '0;
      end else begin
         de   <= st_act;
         rgb  <= st_act ? pix : '0;
         prev <= st_act ? pix : '0;
      end
   end
endmodule

// File: tb/tb_ddp_scaler.sv
// Scoreboard bench for ddp_scaler: stimulus pushes expected pixels, a monitor pops them
// whenever de is high; raddr and frame_done are checked against hand-derived raster values.
module tb_ddp_scaler;
   localparam int DW = 15, H_LEN = 4, V_LEN = 2, SCALE = 4, CW = 4, RD_LAT = 1;
   localparam int PW = 3 * CW;

   logic          pclk = 1'b0;
   logic          rstn, hen, ven;
   logic [1:0]    mode;
   logic [PW-1:0] rdata, rgb;
   logic [DW-1:0] raddr;
   logic          de, frame_done;

   int n_chk  = 0;
   int n_fail = 0;
   int fd_cnt = 0;
   bit mon_en = 0;
   logic [PW-1:0] exp_q[$];

   always #5 pclk = ~pclk;

   ddp_scaler #(.DW(DW), .H_LEN(H_LEN), .V_LEN(V_LEN), .SCALE(SCALE), .CW(CW), .RD_LAT(RD_LAT)) dut (
      .pclk(pclk), .rstn(rstn), .hen(hen), .ven(ven), .mode(mode), .rdata(rdata),
      .raddr(raddr), .rgb(rgb), .de(de), .frame_done(frame_done)
   );

   // Canvas contents; first pair exercises blend, 2 and 3 the gray/dim vectors.
   logic [PW-1:0] mem [8] = '{12'hF00, 12'h000, 12'hF80, 12'hFA6, 12'h123, 12'h8C4, 12'hFFF, 12'h05A};
   logic [PW-1:0] rd_pipe [RD_LAT];

   always @(posedge pclk) begin
      rd_pipe[0] <= (raddr < DW'(8)) ? mem[raddr[2:0]] : '0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign rdata = rd_pipe[RD_LAT-1];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   function automatic logic [PW-1:0] model(input logic [PW-1:0] p, input logic [PW-1:0] q,
                                           input logic [1:0] m, input bit first);
      int r, g, b, qr, qg, qb, y;
      r  = int'(p[2*CW +: CW]); g  = int'(p[CW +: CW]); b  = int'(p[0 +: CW]);
      qr = int'(q[2*CW +: CW]); qg = int'(q[CW +: CW]); qb = int'(q[0 +: CW]);
      y  = (r + 2 * g + b) / 4;
      case (m)
         2'd1:    return first ? p : {CW'((r + qr) / 2), CW'((g + qg) / 2), CW'((b + qb) / 2)};
         2'd2:    return {CW'(y), CW'(y), CW'(y)};
         2'd3:    return {CW'(r / 2), CW'(g / 2), CW'(b / 2)};
         default: return p;
      endcase
   endfunction

   // Monitor: every de pixel must match the head of the queue; blanking must be black.
   always @(negedge pclk) begin
      if (mon_en) begin
         if (frame_done === 1'b1) fd_cnt++;
         if (de === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rgb_unexpected: got %0h with no expected pixel at %0t", rgb, $time);
            end else begin
               check("rgb", rgb, exp_q.pop_front());
            end
         end else begin
            check("rgb_blank", rgb, 0);
         end
      end
   end

   // One screen line of hlen active cycles; expected addresses and pixels from the raster model.
   task automatic run_line(input int l, input int hlen, input logic [1:0] m);
      int lb, idx;
      logic [PW-1:0] prv, o;
      lb  = (l / SCALE) * H_LEN;
      prv = '0;
      for (int k = 0; k < hlen; k++) begin
         hen = 1'b1;
         idx = (k / SCALE < H_LEN) ? k / SCALE : H_LEN - 1;
         if (k >= H_LEN * SCALE) o = '0;
         else o = model(mem[lb + idx], prv, m, k == 0);
         prv = o;
         exp_q.push_back(o);
         @(negedge pclk);
         check("raddr", raddr, lb + idx);
         tick();
      end
      hen = 1'b0;
      repeat (4) tick();
   endtask

   task automatic run_frame(input int hlen, input logic [1:0] m_start, input logic [1:0] m_mid);
      int fd0;
      mode = m_start;
      ven  = 1'b0;
      repeat (2) tick();
      fd0 = fd_cnt;
      ven = 1'b1;
      for (int l = 0; l < V_LEN * SCALE; l++) begin
         if (l == 2) mode = m_mid;
         run_line(l, hlen, m_start);
      end
      check("frame_done_early", fd_cnt, fd0);
      ven = 1'b0;
      repeat (4) tick();
      check("frame_done_pulse", fd_cnt, fd0 + 1);
      check("sb_drained", exp_q.size(), 0);
   endtask

   initial begin
      rstn = 1'b0; hen = 1'b0; ven = 1'b0; mode = 2'd0;
      repeat (2) tick();
      @(negedge pclk);
      check("rst_raddr", raddr, 0);
      check("rst_rgb", rgb, 0);
      check("rst_de", de, 0);
      check("rst_frame_done", frame_done, 0);
      tick();
      rstn   = 1'b1;
      mon_en = 1'b1;

      run_frame(16, 2'd0, 2'd0);   // raster addressing, pass-through
      run_frame(16, 2'd1, 2'd1);   // horizontal blend
      run_frame(16, 2'd2, 2'd2);   // gray
      run_frame(16, 2'd3, 2'd3);   // dim
      run_frame(20, 2'd0, 2'd0);   // overrun past canvas width
      run_frame(16, 2'd0, 2'd3);   // mid-frame mode change ignored
      run_frame(16, 2'd3, 2'd3);   // new mode after ven low

      // Reset in the middle of a line.
      mode = 2'd2;
      ven  = 1'b0;
      repeat (2) tick();
      ven = 1'b1;
      for (int k = 0; k < 6; k++) begin
         hen = 1'b1;
         exp_q.push_back(model(mem[k / SCALE], '0, 2'd2, 1'b0));
         tick();
      end
      rstn = 1'b0; hen = 1'b0; ven = 1'b0;
      tick();
      @(negedge pclk);
      check("midrst_raddr", raddr, 0);
      check("midrst_rgb", rgb, 0);
      check("midrst_de", de, 0);
      exp_q.delete();
      tick();
      rstn = 1'b1;
      run_frame(16, 2'd2, 2'd2);

      repeat (4) tick();
      check("sb_final", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
